pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 22 ++
 rtl/pipe_hazard_ctrl_load_use_detect.sv | 18 +
 rtl/pipe_hazard_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller and control_unit:
// controller state encoding and the opcode constants decoded in IF/ID.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } hazard_state_t;

  localparam logic [5:0] R_TYPE = 6'b000000;
  localparam logic [5:0] LW     = 6'b100011;
  localparam logic [5:0] SW     = 6'b101011;
  localparam logic [5:0] BEQ    = 6'b000100;
  localparam logic [5:0] I_TYPE = 6'b001000;

  // Instructions that read rt as a source operand (rt is a destination otherwise).
  function automatic logic reads_rt(input logic [5:0] opcode);
    return (opcode == R_TYPE) || (opcode == SW) || (opcode == BEQ);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: a load in ID/EX whose destination is a
// source operand of the instruction in IF/ID. Register 0 never conflicts.
module load_use_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [5:0] ifid_opcode,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       idex_memread,
  input  logic [4:0] idex_rt,
  output logic       hazard
);

  assign hazard = idex_memread && (idex_rt != 5'd0) &&
                  ((idex_rt == ifid_rs) ||
                   (reads_rt(ifid_opcode) && (idex_rt == ifid_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: data-memory wait/timeout FSM, branch flush and
// load-use stall arbitration. Optional perf counters (stall_cnt, flush_cnt)
// are built when HAZARD_PERF_CNT_EN is defined.
//
// state       | meaning
// ST_RUN      | normal flow; branch flush / load-use stall arbitration
// ST_MEM_WAIT | data memory access pending; pipeline frozen until ack
// ST_ERROR    | memory timeout; pipeline frozen until reset
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] ifid_opcode,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       idex_memread,
  input  logic [4:0] idex_rt,
  input  logic       branch_taken,
  input  logic       exmem_memacc,
  input  logic       dmem_ack,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       lw_hazard,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic       freeze,
  output logic       mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  hazard_state_t state, state_nxt;
  logic [7:0]    wait_cnt, wait_cnt_nxt;
  logic          mem_err_nxt;
  logic          mem_wait;
  logic          lu_hazard;
  logic          flush_evt;

  assign mem_wait = exmem_memacc && !dmem_ack;

  load_use_detect u_load_use_detect (
    .ifid_opcode  (ifid_opcode),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .hazard       (lu_hazard)
  );

  // State, wait counter and sticky error register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      wait_cnt <= 8'd0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      mem_err  <= mem_err_nxt;
    end
  end

  // Next-state: enter wait on an unacked access, leave on ack or timeout.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    mem_err_nxt  = mem_err;
    case (state)
      ST_RUN: begin
        if (mem_wait) begin
          state_nxt    = ST_MEM_WAIT;
          wait_cnt_nxt = 8'd1;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ack) begin
          state_nxt    = ST_RUN;
          wait_cnt_nxt = 8'd0;
        end else if (wait_cnt == TIMEOUT_CNT) begin
          state_nxt   = ST_ERROR;
          mem_err_nxt = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      ST_ERROR: begin
        state_nxt = ST_ERROR;
      end
      default: begin
        state_nxt    = ST_RUN;
        wait_cnt_nxt = 8'd0;
      end
    endcase
  end

  // Outputs: freeze overrides flush, which overrides the load-use stall.
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    lw_hazard  = 1'b0;
    flush_evt  = 1'b0;
    freeze     = 1'b0;
    case (state)
      ST_RUN: begin
        if (mem_wait) begin
          freeze = 1'b1;
        end else if (branch_taken) begin
          flush_evt = 1'b1;
        end else if (lu_hazard) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          lw_hazard  = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        freeze = !dmem_ack;
      end
      default: begin
        freeze = 1'b1;
      end
    endcase
    if (freeze) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end
  end

  assign ifid_flush  = flush_evt;
  assign idex_flush  = flush_evt;
  assign exmem_flush = flush_evt;

`ifdef HAZARD_PERF_CNT_EN
  // Saturating stall and flush event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if ((lw_hazard || freeze) && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
      if (flush_evt && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule
